lfsr_seq_checker: RTL
=====================

Name: lfsr_seq_checker

Overview:
- Receive-side checker for the 8-bit LFSR byte stream produced by the team's random generator.
- Samples a byte stream, self-synchronises to the LFSR sequence, then flags and counts every byte that deviates from the predicted sequence.
- Sits at the sink of a PRBS/loopback test path. Provides lock status, a per-error pulse and a saturating error counter for display.

Parameters:
- LOCK_CNT, 4: consecutive matching bytes in VERIFY needed to declare lock. Legal range 1..15.
- LOSS_CNT, 3: consecutive mismatching bytes in LOCKED that cause loss of lock. Legal range 1..15.
- CNT_W, 16: width of the error counter.

Ports:
- clk, input, 1: clock, rising edge.
- rs, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous clear of err_cnt.
- in_valid, input, 1: data_in is sampled on this edge.
- data_in, input, 8: received LFSR byte.
- locked, output, 1: high while state is LOCKED.
- state, output, 2: HUNT=0, VERIFY=1, LOCKED=2.
- err, output, 1: one-cycle pulse per mismatching byte while LOCKED.
- err_cnt, output, CNT_W: saturating mismatch count.
- expected, output, 8: predicted value of the next byte.

Behaviour:
- Prediction function: nxt(q) = {q[4]^q[3]^q[2]^q[0]^(q==8'h00), q[7:1]}. This is bit-exact with the generator, so nxt(8'h00)=8'h80.
- Reset (async, rs=1): state=HUNT, locked=0, err=0, err_cnt=0, expected=0, match_run=0, miss_run=0.
- Register rules:
  - All outputs are registered, or decoded directly from registers (locked = state==LOCKED).
  - err defaults to 0 every cycle.
- in_valid=0: all state, runs, expected and err_cnt hold; err=0.
- HUNT (valid byte d): expected<=nxt(d); match_run<=0; go to VERIFY.
- VERIFY (valid byte d):
  - Match (d==expected): expected<=nxt(expected); match_run+1. If match_run+1==LOCK_CNT, go to LOCKED with miss_run<=0.
  - Mismatch: reseed with expected<=nxt(d) and match_run<=0; stay in VERIFY.
  - No err pulse and no count change in VERIFY.
- LOCKED (valid byte d):
  - expected<=nxt(expected) always, match or not. Received bytes never reseed the predictor here.
  - Match: miss_run<=0.
  - Mismatch: err<=1; err_cnt increments, saturating at all-ones; miss_run+1.
  - If miss_run+1==LOSS_CNT, go to HUNT (locked drops the next cycle).
- Latency: locked rises, and err pulses, in the cycle after the edge that sampled the deciding byte.
- clr:
  - Clears err_cnt to 0, with priority over an increment in the same cycle.
  - The err pulse still fires.
  - clr does not affect state, runs or expected.
- Reset mid-operation: immediate return to reset values, independent of clk.
- Widths: match_run and miss_run are 4 bits. err_cnt never wraps.

Test Plan:
- Lock from seed:
  - Stimulus: rs pulse, then valid bytes 0x01,0x80,0x40,0x20,0x10.
  - Required: state=VERIFY after 0x01; locked=1 the cycle after 0x10 is sampled; err_cnt=0; expected=0x88.
- Single error tolerated:
  - Stimulus: while locked, send 0x88, then 0x00 in place of 0xC4, then 0xE2.
  - Required: one err pulse; err_cnt=1; locked stays 1; no error on 0xE2 (predictor advanced through 0xC4).
- Loss of lock:
  - Stimulus: while locked, send three consecutive wrong bytes (0xFF,0xFF,0xFF).
  - Required: three err pulses; err_cnt +3; state=HUNT and locked=0 after the third.
- VERIFY reseed:
  - Stimulus: after reset send 0x01,0x80,0x55.
  - Required: state stays VERIFY; no err; expected=0xAA. Then 0xAA,0xD5 plus two more correct successors gives locked=1.
- Zero state and gaps:
  - Stimulus: seed 0x00, then 0x80,0x40,0x20,0x10, with in_valid=0 idle cycles interleaved.
  - Required: locks; idle cycles change nothing.
- clr and saturation:
  - Stimulus: clr coincident with a LOCKED mismatch.
  - Required: err=1 and err_cnt=0.
  - Stimulus: with CNT_W=2, five errors.
  - Required: err_cnt=3.
  - Stimulus: rs asserted mid-LOCKED.
  - Required: outputs reset without waiting for a clk edge.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 8-bit LFSR byte stream: self-synchronises to the
// sequence, then flags and counts every byte that deviates from the prediction.
module lfsr_seq_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       data_in,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       expected
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

    state_t     st;
    logic [3:0] match_run;
    logic [3:0] miss_run;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    // The (q == 0) term keeps the all-zero byte from locking up the sequence.
    function automatic logic [7:0] nxt(input logic [7:0] q);
        return {q[4] ^ q[3] ^ q[2] ^ q[0] ^ (q == 8'h00), q[7:1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        return c + CNT_W'(1);
    endfunction

    assign match_inc = match_run + 4'd1;
    assign miss_inc  = miss_run + 4'd1;
    assign state     = st;
    assign locked    = (st == LOCKED);

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            st        <= HUNT;
            match_run <= 4'd0;
            miss_run  <= 4'd0;
            expected  <= 8'h00;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                case (st)
                    HUNT: begin
                        expected  <= nxt(data_in);
                        match_run <= 4'd0;
                        st        <= VERIFY;
                    end
                    VERIFY: begin
                        if (data_in == expected) begin
                            expected  <= nxt(expected);
                            match_run <= match_inc;
                            if (match_inc == LOCK_LIM) begin
                                st       <= LOCKED;
                                miss_run <= 4'd0;
                            end
                        end else begin
                            expected  <= nxt(data_in);
                            match_run <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Free-running predictor: received bytes never reseed it here.
                        expected <= nxt(expected);
                        if (data_in == expected) begin
                            miss_run <= 4'd0;
                        end else begin
                            err      <= 1'b1;
                            err_cnt  <= sat_inc(err_cnt);
                            miss_run <= miss_inc;
                            if (miss_inc == LOSS_LIM)
                                st <= HUNT;
                        end
                    end
                    default: st <= HUNT;
                endcase
            end
            // Placed last so a clear wins over a same-cycle increment.
            if (clr)
                err_cnt <= '0;
        end
    end

endmodule
